// File: rtl/shiftmul_sequencer_pkg.sv
// Shared constants for the shift-add multiplier sequencer.
//   mode_t  : shift-register mode encoding, shared by both external registers
//             and the sequencer (HOLD=00, RIGHT=01, LEFT=10, PLOAD=11).
//   state_t : sequencer FSM states (IDLE=0, LOAD=1, RUN=2, DONE=3).
package shiftmul_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_PLOAD = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/shiftmul_sequencer_shreg.sv
// Universal shift register driven by the sequencer (one for the 2W-bit
// multiplicand, one for the W-bit multiplier).
// Ports:
//   clk, reset_n : clock, async active-low reset
//   mode         : HOLD / RIGHT (serial enters MSB) / LEFT (serial enters LSB) / PLOAD
//   load         : parallel-load value
//   serial       : serial input bit
//   value        : parallel output
module shiftmul_sequencer_shreg
  import shiftmul_sequencer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   mode,
  input  logic [W-1:0] load,
  input  logic         serial,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else begin
      case (mode_t'(mode))
        MODE_RIGHT: value <= {serial, value[W-1:1]};
        MODE_LEFT:  value <= {value[W-2:0], serial};
        MODE_PLOAD: value <= load;
        default:    value <= value;
      endcase
    end
  end

endmodule

// File: rtl/shiftmul_sequencer.sv
// Control FSM for a shift-add unsigned multiplier built from two external
// shift registers. Owns the 2W-bit accumulator and a start/done handshake.
// Ports:
//   clk, reset_n   : clock, async active-low reset
//   start          : multiply request, honoured only in IDLE
//   op_a, op_b     : operands, captured on the accepted start edge
//   a_value        : multiplicand register output (A << i during RUN cycle i)
//   b_lsb          : multiplier register bit 0 (B[i] during RUN cycle i)
//   a_mode, b_mode : shift-register modes
//   a_load, b_load : parallel-load data for the two registers
//   a_serial, b_serial : serial inputs, always 0
//   ready / busy / done : IDLE / LOAD+RUN / DONE (one-cycle pulse)
//   product        : accumulator; holds from DONE until the next LOAD
module shiftmul_sequencer
  import shiftmul_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [2*WIDTH-1:0] a_value,
  input  logic               b_lsb,
  output logic [1:0]         a_mode,
  output logic [1:0]         b_mode,
  output logic [2*WIDTH-1:0] a_load,
  output logic [WIDTH-1:0]   b_load,
  output logic               a_serial,
  output logic               b_serial,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     acc;
  logic [WIDTH-1:0]  cap_a, cap_b;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // next state and mode decode; outputs depend on state only
  always_comb begin
    state_nxt = S_IDLE;
    a_mode    = MODE_HOLD;
    b_mode    = MODE_HOLD;
    case (state)
      S_IDLE: state_nxt = start ? S_LOAD : S_IDLE;
      S_LOAD: begin
        a_mode    = MODE_PLOAD;
        b_mode    = MODE_PLOAD;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        a_mode    = MODE_LEFT;
        b_mode    = MODE_RIGHT;
        state_nxt = (cnt == CNT_LAST) ? S_DONE : S_RUN;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // operand capture, counter and accumulator
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_a <= '0;
      cap_b <= '0;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cap_a <= op_a;
            cap_b <= op_b;
          end
        end
        S_LOAD: begin
          acc <= '0;
          cnt <= '0;
        end
        S_RUN: begin
          // a_value already holds A<<i this cycle; the register shifts on
          // this same edge, so the add uses the pre-shift value.
          if (b_lsb) acc <= acc + a_value;
          if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign a_load   = {{WIDTH{1'b0}}, cap_a};
  assign b_load   = cap_b;
  assign a_serial = 1'b0;
  assign b_serial = 1'b0;
  assign ready    = (state == S_IDLE);
  assign busy     = (state == S_LOAD) || (state == S_RUN);
  assign done     = (state == S_DONE);
  assign product  = acc;

endmodule

// File: tb/tb_shiftmul_sequencer.sv
module tb_shiftmul_sequencer;
  import shiftmul_sequencer_pkg::*;

  localparam int WIDTH = 8;
  localparam int PW    = 2 * WIDTH;
  localparam int LAT   = WIDTH + 1;  // ticks from start edge to DONE

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] op_a = '0, op_b = '0;
  logic [PW-1:0]    a_value, a_load, product;
  logic [WIDTH-1:0] b_value, b_load;
  logic [1:0]       a_mode, b_mode;
  logic             a_serial, b_serial, ready, busy, done;

  always #5 clk = ~clk;

  shiftmul_sequencer_shreg #(.W(PW)) u_a (
    .clk(clk), .reset_n(reset_n), .mode(a_mode), .load(a_load),
    .serial(a_serial), .value(a_value));

  shiftmul_sequencer_shreg #(.W(WIDTH)) u_b (
    .clk(clk), .reset_n(reset_n), .mode(b_mode), .load(b_load),
    .serial(b_serial), .value(b_value));

  shiftmul_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op_a(op_a), .op_b(op_b),
    .a_value(a_value), .b_lsb(b_value[0]), .a_mode(a_mode), .b_mode(b_mode),
    .a_load(a_load), .b_load(b_load), .a_serial(a_serial), .b_serial(b_serial),
    .ready(ready), .busy(busy), .done(done), .product(product));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // wait for done, return ticks taken (-1 on timeout)
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [PW-1:0]    p;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat, t0, t1;
    bit seen;

    vecs[0] = '{8'd13,  8'd11,  16'd143};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{8'd0,   8'd200, 16'd0};
    vecs[3] = '{8'd77,  8'd0,   16'd0};
    vecs[4] = '{8'd128, 8'd2,   16'd256};
    vecs[5] = '{8'd1,   8'd1,   16'd1};

    // reset state
    #3;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_amode", a_mode, MODE_HOLD);
    check("rst_bmode", b_mode, MODE_HOLD);
    check("rst_product", product, 0);
    check("rst_aload", a_load, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // mode trace for 13*11
    op_a = 8'd13; op_b = 8'd11; start = 1'b1;
    tick();
    start = 1'b0;
    check("trace_load_amode", a_mode, MODE_PLOAD);
    check("trace_load_bmode", b_mode, MODE_PLOAD);
    check("trace_load_busy", busy, 1);
    check("trace_bload", b_load, 11);
    for (int i = 0; i < WIDTH; i++) begin
      tick();
      check($sformatf("trace_run%0d_modes", i), {a_mode, b_mode}, {MODE_LEFT, MODE_RIGHT});
      check($sformatf("trace_run%0d_done", i), done, 0);
    end
    tick();
    check("trace_done", done, 1);
    check("trace_done_modes", {a_mode, b_mode}, {MODE_HOLD, MODE_HOLD});
    check("trace_product", product, 143);
    check("trace_a_shifted", a_value, 16'd13 << WIDTH);
    check("trace_b_shifted", b_value, 0);
    tick();
    check("trace_idle_done", done, 0);
    check("trace_idle_ready", ready, 1);

    // table-driven products and latency
    foreach (vecs[i]) begin
      op_a = vecs[i].a; op_b = vecs[i].b; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(lat);
      check($sformatf("vec%0d_latency", i), lat, LAT);
      check($sformatf("vec%0d_product", i), product, vecs[i].p);
      tick();
      check($sformatf("vec%0d_pulse", i), done, 0);
      check($sformatf("vec%0d_hold", i), product, vecs[i].p);
      tick();
    end

    // start during RUN and DONE is ignored
    op_a = 8'd10; op_b = 8'd10; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    op_a = 8'd3; op_b = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_run_ready", ready, 0);
    wait_done(lat);
    check("ign_latency", lat, LAT - 4);
    check("ign_product", product, 100);
    check("ign_done_ready", ready, 0);
    op_a = 8'd4; op_b = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_idle_ready", ready, 1);
    check("ign_capture", a_load, 10);
    check("ign_product_hold", product, 100);
    tick();
    check("ign_no_load", busy, 0);

    // reset during RUN cycle 4
    op_a = 8'd200; op_b = 8'd99; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("rr_in_run", a_mode, MODE_LEFT);
    reset_n = 1'b0;
    #1;
    check("rr_ready", ready, 1);
    check("rr_busy", busy, 0);
    check("rr_product", product, 0);
    check("rr_modes", {a_mode, b_mode}, {MODE_HOLD, MODE_HOLD});
    tick();
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done) seen = 1;
    end
    check("rr_no_done", seen, 0);
    op_a = 8'd6; op_b = 8'd7; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat);
    check("rr_after_latency", lat, LAT);
    check("rr_after_product", product, 42);
    tick();

    // back-to-back with start held high
    op_a = 8'd3; op_b = 8'd5; start = 1'b1;
    tick();
    op_a = 8'd9; op_b = 8'd9;
    wait_done(lat);
    t0 = lat;
    check("b2b_first", product, 15);
    tick();
    check("b2b_idle_ready", ready, 1);
    check("b2b_idle_hold", product, 15);
    tick();
    check("b2b_load_busy", busy, 1);
    check("b2b_load_hold", product, 15);
    start = 1'b0;
    wait_done(lat);
    t1 = (lat < 0) ? -1 : lat + 2;
    check("b2b_gap", t1, 11);
    check("b2b_second", product, 81);
    check("b2b_first_latency", t0, LAT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
